// File: rtl/cpu_mc.sv
// cpu_mc: multi-cycle RV32I/RV32E-subset core sequenced FETCH -> DECODE -> EXEC -> MEM -> WB.
// Instruction and data memories sit behind req/ready ports and may insert wait states.
module cpu_mc #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          NUM_REGS = 32
) (
   input  logic        clock,
   input  logic        reset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   input  logic        dmem_ready,
   input  logic [31:0] dmem_rdata,
   output logic        zero,
   output logic        retire,
   output logic        halt
);
   localparam int AW = $clog2(NUM_REGS);
   localparam logic [6:0] OP_R  = 7'b0110011;
   localparam logic [6:0] OP_I  = 7'b0010011;
   localparam logic [6:0] OP_LW = 7'b0000011;
   localparam logic [6:0] OP_SW = 7'b0100011;
   localparam logic [6:0] OP_BR = 7'b1100011;

   typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d, ir_q, ir_d, a_q, a_d, b_q, b_d, imm_q, imm_d, res_q, res_d;
   logic        zero_q, zero_d, halt_q, halt_d;
   logic [31:0] rf_q [NUM_REGS];
   logic [31:0] rf_d [NUM_REGS];

   logic [6:0]  opcode, funct7;
   logic [4:0]  rd, rs1, rs2;
   logic [2:0]  funct3;
   logic        is_r, is_i, is_lw, is_sw, is_br, legal, bad_idx;
   logic [31:0] op2, alu_y, target, addr;
   logic        eq, taken, br_bad;

   assign opcode = ir_q[6:0];
   assign rd     = ir_q[11:7];
   assign funct3 = ir_q[14:12];
   assign rs1    = ir_q[19:15];
   assign rs2    = ir_q[24:20];
   assign funct7 = ir_q[31:25];

   // Only fields that a format actually uses are checked against the RV32E register limit.
   always_comb begin
      is_r  = (opcode == OP_R) && ((funct7 == 7'h00) ||
              ((funct7 == 7'h20) && ((funct3 == 3'd0) || (funct3 == 3'd5))));
      is_i  = (opcode == OP_I) && ((funct3 == 3'd1) ? (funct7 == 7'h00) :
              (funct3 == 3'd5) ? ((funct7 == 7'h00) || (funct7 == 7'h20)) : 1'b1);
      is_lw = (opcode == OP_LW) && (funct3 == 3'd2);
      is_sw = (opcode == OP_SW) && (funct3 == 3'd2);
      is_br = (opcode == OP_BR) && (funct3[2:1] == 2'b00);
      legal = is_r || is_i || is_lw || is_sw || is_br;
      bad_idx = (NUM_REGS == 16) &&
                (((is_r || is_i || is_lw) && rd[4]) ||
                 (legal && rs1[4]) ||
                 ((is_r || is_sw || is_br) && rs2[4]));
   end

   always_comb begin
      op2 = (opcode == OP_R) ? b_q : imm_q;
      case (funct3)
         3'd0:    alu_y = ((opcode == OP_R) && funct7[5]) ? a_q - op2 : a_q + op2;
         3'd1:    alu_y = a_q << op2[4:0];
         3'd2:    alu_y = {31'd0, $signed(a_q) < $signed(op2)};
         3'd3:    alu_y = {31'd0, a_q < op2};
         3'd4:    alu_y = a_q ^ op2;
         3'd5:    alu_y = funct7[5] ? $unsigned($signed(a_q) >>> op2[4:0]) : a_q >> op2[4:0];
         3'd6:    alu_y = a_q | op2;
         default: alu_y = a_q & op2;
      endcase
      eq     = (a_q == b_q);
      taken  = funct3[0] ? !eq : eq;
      target = pc_q + imm_q;
      br_bad = taken && target[1];
      addr   = a_q + imm_q;
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ir_d    = ir_q;
      a_d     = a_q;
      b_d     = b_q;
      imm_d   = imm_q;
      res_d   = res_q;
      zero_d  = zero_q;
      halt_d  = halt_q;
      rf_d    = rf_q;
      case (state_q)
         S_FETCH: begin
            if (imem_ready) begin
               ir_d    = imem_rdata;
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            a_d = rf_q[rs1[AW-1:0]];
            b_d = rf_q[rs2[AW-1:0]];
            case (opcode)
               OP_SW:   imm_d = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
               OP_BR:   imm_d = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
               default: imm_d = {{20{ir_q[31]}}, ir_q[31:20]};
            endcase
            if (!legal || bad_idx) begin
               state_d = S_HALT;
               halt_d  = 1'b1;
            end else begin
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            if (is_lw || is_sw) begin
               res_d = addr;
               if (addr[1:0] != 2'b00) begin
                  state_d = S_HALT;
                  halt_d  = 1'b1;
               end else begin
                  state_d = S_MEM;
               end
            end else if (is_br) begin
               zero_d = eq;
               if (br_bad) begin
                  state_d = S_HALT;
                  halt_d  = 1'b1;
               end else begin
                  pc_d    = taken ? target : pc_q + 32'd4;
                  state_d = S_FETCH;
               end
            end else begin
               res_d   = alu_y;
               zero_d  = (alu_y == 32'd0);
               state_d = S_WB;
            end
         end
         S_MEM: begin
            if (dmem_ready) begin
               if (is_sw) begin
                  pc_d    = pc_q + 32'd4;
                  state_d = S_FETCH;
               end else begin
                  res_d   = dmem_rdata;
                  state_d = S_WB;
               end
            end
         end
         S_WB: begin
            if (rd != 5'd0) rf_d[rd[AW-1:0]] = res_q;
            pc_d    = pc_q + 32'd4;
            state_d = S_FETCH;
         end
         S_HALT: halt_d = 1'b1;
         default: begin
            state_d = S_HALT;
            halt_d  = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= S_FETCH;
         pc_q    <= RESET_PC;
         ir_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         imm_q   <= '0;
         res_q   <= '0;
         zero_q  <= 1'b0;
         halt_q  <= 1'b0;
         for (int i = 0; i < NUM_REGS; i++) rf_q[i] <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
         a_q     <= a_d;
         b_q     <= b_d;
         imm_q   <= imm_d;
         res_q   <= res_d;
         zero_q  <= zero_d;
         halt_q  <= halt_d;
         rf_q    <= rf_d;
      end
   end

   // Requests are gated by reset so an in-flight access drops in the very cycle reset rises.
   assign imem_req   = (state_q == S_FETCH) && !reset;
   assign imem_addr  = pc_q;
   assign dmem_req   = (state_q == S_MEM) && !reset;
   assign dmem_we    = is_sw;
   assign dmem_addr  = res_q;
   assign dmem_wdata = b_q;
   assign zero       = zero_q;
   assign halt       = halt_q;
   assign retire     = !reset && ((state_q == S_WB) ||
                                  ((state_q == S_MEM) && is_sw && dmem_ready) ||
                                  ((state_q == S_EXEC) && is_br && !br_bad));
endmodule

// File: doc/cpu_mc.md
# cpu_mc

Multi-cycle RV32I-subset core, the next generation of our single-cycle `cpu`. It replaces hard-wired instruction fetch and a register-only datapath with a FETCH/DECODE/EXEC/MEM/WB state machine. Instruction and data memories sit behind external request/ready ports and may insert wait states. It adds immediates, loads/stores and branches, and is parametrised in reset vector and register-file depth (RV32I or RV32E).

## Interface

- `RESET_PC`, 32'h0000_0000, PC value loaded on reset.
- `NUM_REGS`, 32, register-file depth; legal values are 32 (RV32I) and 16 (RV32E).
- `clock` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high.
- `imem_req` output 1: instruction fetch request.
- `imem_addr` output 32: fetch address (current PC).
- `imem_ready` input 1: fetch completes on the edge where `imem_req && imem_ready`.
- `imem_rdata` input 32: instruction word, valid while `imem_ready`.
- `dmem_req` output 1: data access request.
- `dmem_we` output 1: 1 = store, 0 = load.
- `dmem_addr` output 32: word address (byte-addressed, 4-aligned).
- `dmem_wdata` output 32: store data.
- `dmem_ready` input 1: access completes on the edge where `dmem_req && dmem_ready`.
- `dmem_rdata` input 32: load data, valid while `dmem_ready`.
- `zero` output 1: registered, 1 when the last EXEC ALU result was 0.
- `retire` output 1: one-cycle pulse when an instruction completes.
- `halt` output 1: sticky; core stopped.

## Operation

- Supported instructions:
  - R-type: ADD SUB AND OR XOR SLL SRL SRA SLT SLTU.
  - I-type: ADDI ANDI ORI XORI SLTI SLTIU SLLI SRLI SRAI.
  - LW, SW, BEQ, BNE, ECALL.
- Any other encoding goes to HALT.
- States and transitions:
  - FETCH: `imem_req`=1, `imem_addr`=PC. Stay until ready, then latch IR and go to DECODE.
  - DECODE: read rs1/rs2 into A/B, sign-extend the immediate, go to EXEC. Illegal opcode, ECALL, or (when `NUM_REGS`=16) any rs1/rs2/rd index ≥16 goes to HALT.
  - EXEC:
    - ALU ops: compute result, update `zero`, go to WB.
    - LW/SW: address = A+imm. A misaligned address (bits [1:0]≠0) goes to HALT; otherwise go to MEM.
    - BEQ/BNE: `zero` = (A−B==0). Taken: PC ← PC+imm; untaken: PC ← PC+4. Pulse `retire` and go to FETCH. A taken target with bit 1 set goes to HALT, and the PC is not updated.
  - MEM: `dmem_req`=1, stay until ready.
    - LW: latch `dmem_rdata`, go to WB.
    - SW: PC ← PC+4, pulse `retire`, go to FETCH.
  - WB: write rd when rd≠0 (x0 always reads 0), PC ← PC+4, pulse `retire`, go to FETCH.
  - HALT: terminal; `halt`=1; no requests issued; exit only via reset.
- Arithmetic:
  - All ALU ops are 32-bit modulo.
  - Shift amount is the low 5 bits of B or of the immediate.
  - SRA/SRAI are arithmetic shifts.
  - SLT is signed; SLTU is unsigned.
  - PC arithmetic wraps at 2^32.
- Outputs remain stable while a request waits: address, write data and we do not change until ready.

## Timing

- Reset values:
  - PC=`RESET_PC`, state=FETCH, all registers 0.
  - `zero`=0, `retire`=0, `halt`=0.
  - `imem_req`=0 and `dmem_req`=0 during every cycle `reset` is high.
- The first fetch request appears in the first cycle after `reset` deasserts.
- Ready may be high in the same cycle the request rises (zero-wait memory).
- Each wait cycle adds exactly one cycle. Ready while the request is low is ignored.
- Latency with zero-wait memory, counted FETCH-entry to FETCH-entry:
  - ALU: 4 cycles.
  - LW: 5 cycles.
  - SW: 4 cycles.
  - Branch: 3 cycles.
- `retire` is high in the final cycle of each instruction. It never pulses for a halting instruction.
- Reset mid-transaction (any state, including MEM with a pending store) abandons the access. The request drops in that cycle and the next fetch is from `RESET_PC`. Memory must tolerate a dropped request.
- Register writes occur on the WB exit edge. A following instruction's DECODE sees the new value, so no forwarding is needed.

## Test plan

- ADDI x1,x0,5; ADDI x2,x0,-3; ADD x3,x1,x2; SUB x4,x1,x1 with zero-wait memory → x3=2, x4=0. `zero` is 0 after the ADD and 1 after the SUB. `retire` pulses at cycles 4, 8, 12, 16 after reset release.
- SW x1,8(x0), then LW x5,8(x0) → store cycle shows `dmem_addr`=8, `dmem_we`=1, `dmem_wdata`=5. x5=5. Load retires 5 cycles after its fetch.
- PC=0x10: BEQ x1,x1,+12 → next fetch at 0x1C (3 cycles). BNE x1,x1,+12 → next fetch at 0x14.
- `imem_ready` held low 3 cycles → `imem_req` and `imem_addr` are stable for 4 cycles, the state does not advance, and the instruction retires 3 cycles late. Repeat with `dmem_ready` for LW.
- ADDI x0,x0,7 → x0 reads 0. With `NUM_REGS`=16, ADD x17,x1,x2 → `halt`=1, no `retire`, no further requests. Unknown opcode 7'h7F → same result.
- Assert `reset` during MEM of an SW at 0x40 → `dmem_req` drops that cycle. The next `imem_addr` is `RESET_PC` and all registers read 0.
